// File: rtl/wb_addr_queue.sv
// Write-back store address queue: circular FIFO of pending stores feeding
// the data cache, with a line-granular load/store conflict check.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   enq, enq_*        store request from write-back (addr/data/size/ptcinfo)
//   full, empty       queue status; count = number of valid entries
//   dc_req, dc_*      head entry presented to the data cache
//   dc_ack            cache accepted the head store this cycle
//   chk_addr, chk_hit load address check against queued store lines
//   ovf               sticky flag: enq arrived while full
module wb_addr_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enq,
  input  logic [31:0]    enq_addr,
  input  logic [63:0]    enq_data,
  input  logic [1:0]     enq_size,
  input  logic [127:0]   enq_ptcinfo,
  output logic           full,
  output logic           empty,
  output logic [CW-1:0]  count,
  output logic           dc_req,
  output logic [31:0]    dc_addr,
  output logic [63:0]    dc_data,
  output logic [1:0]     dc_size,
  output logic [127:0]   dc_ptcinfo,
  input  logic           dc_ack,
  input  logic [31:0]    chk_addr,
  output logic           chk_hit,
  output logic           ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [127:0]     ptc_q  [DEPTH];

  logic             do_enq;
  logic             do_deq;
  logic             head_vld;
  logic [DEPTH-1:0] hit_vec;
  logic             unused_chk;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign dc_req = ~empty;

  // Enq is refused whenever full, even if the head leaves this cycle.
  assign do_enq = enq & ~full;
  assign do_deq = dc_req & dc_ack;

  // Gating on the head valid bit forces dc_* to zero during reset.
  assign head_vld   = vld_q[head_q];
  assign dc_addr    = head_vld ? addr_q[head_q] : '0;
  assign dc_data    = head_vld ? data_q[head_q] : '0;
  assign dc_size    = head_vld ? size_q[head_q] : '0;
  assign dc_ptcinfo = head_vld ? ptc_q[head_q]  : '0;

  // Line index of the last byte touched by a store.
  function automatic logic [27:0] last_line(
    input logic [31:0] a,
    input logic [1:0]  s
  );
    logic [31:0] e;
    logic [2:0]  span;
    unique case (s)
      2'b00:   span = 3'd0;
      2'b01:   span = 3'd1;
      2'b10:   span = 3'd3;
      default: span = 3'd7;
    endcase
    e = a + {29'd0, span};
    return e[31:4];
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign hit_vec[g] = vld_q[g] &&
      ((addr_q[g][31:4] == chk_addr[31:4]) ||
       (last_line(addr_q[g], size_q[g]) == chk_addr[31:4]));
  end

  assign chk_hit    = |hit_vec;
  assign unused_chk = ^chk_addr[3:0];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q | (enq & full);
    if (do_enq) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    if (do_deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
        ptc_q[i]  <= '0;
      end
    end else if (do_enq) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
      size_q[tail_q] <= enq_size;
      ptc_q[tail_q]  <= enq_ptcinfo;
    end
  end

endmodule

// File: tb/tb_wb_addr_queue.sv
// Self-checking bench for wb_addr_queue: vector table, scoreboard of
// queued stores, and hand sequences for single store/reset/wrap/conflict.
module tb_wb_addr_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq;
  logic [31:0]   enq_addr;
  logic [63:0]   enq_data;
  logic [1:0]    enq_size;
  logic [127:0]  enq_ptcinfo;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          dc_req;
  logic [31:0]   dc_addr;
  logic [63:0]   dc_data;
  logic [1:0]    dc_size;
  logic [127:0]  dc_ptcinfo;
  logic          dc_ack;
  logic [31:0]   chk_addr;
  logic          chk_hit;
  logic          ovf;

  wb_addr_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .enq(enq), .enq_addr(enq_addr), .enq_data(enq_data),
    .enq_size(enq_size), .enq_ptcinfo(enq_ptcinfo),
    .full(full), .empty(empty), .count(count),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data),
    .dc_size(dc_size), .dc_ptcinfo(dc_ptcinfo), .dc_ack(dc_ack),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  a;
    logic [63:0]  d;
    logic [1:0]   s;
    logic [127:0] p;
  } st_t;

  typedef struct {
    logic        e;
    logic [31:0] a;
    logic [1:0]  s;
    logic        k;
    int          cnt;
    logic        f;
    logic        o;
  } vec_t;

  st_t  sb[$];
  int   m_cnt = 0;
  int   npass = 0;
  int   ntot  = 0;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One clock cycle: drive inputs, score any dequeue, advance, check count.
  task automatic cyc(input logic e, input logic [31:0] a,
                     input logic [63:0] d, input logic [1:0] s,
                     input logic k);
    st_t x;
    enq = e; enq_addr = a; enq_data = d; enq_size = s;
    enq_ptcinfo = {a, d, a}; dc_ack = k;
    #1;
    chk("dc_req", 128'(dc_req), 128'(m_cnt != 0));
    if (k && m_cnt > 0) begin
      x = sb.pop_front();
      chk("sb_addr", 128'(dc_addr), 128'(x.a));
      chk("sb_data", 128'(dc_data), 128'(x.d));
      chk("sb_size", 128'(dc_size), 128'(x.s));
      chk("sb_ptc", dc_ptcinfo, x.p);
    end
    if (e && m_cnt < DEPTH) begin
      x.a = a; x.d = d; x.s = s; x.p = {a, d, a};
      sb.push_back(x);
    end
    m_cnt = m_cnt + ((e && m_cnt < DEPTH) ? 1 : 0) - ((k && m_cnt > 0) ? 1 : 0);
    @(posedge clk);
    #1;
    chk("count", 128'(count), 128'(m_cnt));
    enq = 1'b0; dc_ack = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h3000, 2'd2, 1'b0, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h3010, 2'd1, 1'b0, 2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h3020, 2'd0, 1'b0, 3, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'h3030, 2'd3, 1'b0, 4, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h3040, 2'd2, 1'b0, 4, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 32'h3050, 2'd2, 1'b1, 3, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h3060, 2'd2, 1'b1, 3, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,    2'd0, 1'b1, 2, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,    2'd0, 1'b1, 1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,    2'd0, 1'b1, 0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h0,    2'd0, 1'b1, 0, 1'b0, 1'b1};

    rst = 1'b1; enq = 1'b0; enq_addr = '0; enq_data = '0;
    enq_size = '0; enq_ptcinfo = '0; dc_ack = 1'b0; chk_addr = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_dc_req", 128'(dc_req), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_chk_hit", 128'(chk_hit), 128'(0));
    chk("rst_dc_addr", 128'(dc_addr), 128'(0));
    chk("rst_dc_ptc", dc_ptcinfo, 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single store, held while unacknowledged, then drained.
    cyc(1'b1, 32'h0000_1008, 64'hDEAD_BEEF_0123_4567, 2'b11, 1'b0);
    chk("ss_dc_req", 128'(dc_req), 128'(1));
    chk("ss_addr", 128'(dc_addr), 128'h1008);
    chk("ss_data", 128'(dc_data), 128'hDEAD_BEEF_0123_4567);
    chk("ss_size", 128'(dc_size), 128'(3));
    chk("ss_ptc", dc_ptcinfo,
        128'h0000_1008_DEAD_BEEF_0123_4567_0000_1008);
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    chk("ss_hold", 128'(dc_addr), 128'h1008);
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b1);
    chk("ss_empty", 128'(empty), 128'(1));

    // Fill, overflow, enq-while-full with ack, simultaneous, drain.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].e, tbl[i].a, {tbl[i].a, ~tbl[i].a}, tbl[i].s, tbl[i].k);
      chk($sformatf("tbl%0d_count", i), 128'(count), 128'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i), 128'(full), 128'(tbl[i].f));
      chk($sformatf("tbl%0d_ovf", i), 128'(ovf), 128'(tbl[i].o));
    end
    chk("tbl_sb_empty", 128'(sb.size()), 128'(0));

    // Reset between edges with three entries queued.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h4000 + 32'(i * 16), 64'(i), 2'd2, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("mr_count", 128'(count), 128'(0));
    chk("mr_dc_req", 128'(dc_req), 128'(0));
    chk("mr_ovf", 128'(ovf), 128'(0));
    chk("mr_dc_addr", 128'(dc_addr), 128'(0));
    sb.delete(); m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);

    // Wrap-around: ten stores streamed through with back-to-back acks.
    cyc(1'b1, 32'h100, 64'h100, 2'd0, 1'b0);
    for (int i = 1; i < 10; i++)
      cyc(1'b1, 32'h100 + 32'(i), 64'h100 + 64'(i), 2'd0, 1'b1);
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b1);
    chk("wr_empty", 128'(empty), 128'(1));
    chk("wr_sb_empty", 128'(sb.size()), 128'(0));

    // Line conflict check.
    chk_addr = 32'h2000;
    #1;
    chk("cf_empty_hit", 128'(chk_hit), 128'(0));
    cyc(1'b1, 32'h2004, 64'h1, 2'b10, 1'b0);
    chk_addr = 32'h200C;
    #1;
    chk("cf_same_line", 128'(chk_hit), 128'(1));
    chk_addr = 32'h2010;
    #1;
    chk("cf_next_line", 128'(chk_hit), 128'(0));
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b1);
    cyc(1'b1, 32'h200E, 64'h2, 2'b10, 1'b0);
    chk_addr = 32'h2010;
    #1;
    chk("cf_cross", 128'(chk_hit), 128'(1));
    cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b1);
    #1;
    chk("cf_drained", 128'(chk_hit), 128'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
